ahb_fetch_queue: RTL and testbench
==================================

# ahb_fetch_queue

Instruction prefetch queue between the multicycle ARM core and the AHB-Lite instruction ROM. Issues sequential word fetches, buffers returned words with their PCs in a DEPTH-entry FIFO, and delivers them to the core over a valid/ready handshake. A branch redirect flushes the queue and restarts fetching at the new PC. The ROM is zero-wait-state combinational read, so a fetch completes in the cycle its address is driven, unless the bus holds HREADY low.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- HCLK  in  1  clock; all state updates on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  out  1  fetch request this cycle.
- HADDR  out  32  byte address of fetch; [1:0] always 0.
- HREADY  in  1  bus ready; fetch completes only when HSEL && HREADY.
- HRDATA  in  32  instruction word for current HADDR.
- redirect  in  1  flush and restart at redirect_pc.
- redirect_pc  in  32  new fetch PC; [1:0] ignored (forced 0).
- instr_valid  out  1  head entry valid.
- instr  out  32  head instruction word.
- instr_pc  out  32  PC of head instruction.
- instr_ready  in  1  core accepts head this cycle.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- FSM states: IDLE (entered on reset; HSEL=0), RUN. IDLE -> RUN unconditionally next cycle. RUN holds until reset.
- fetch_pc register; HADDR = fetch_pc at all times.
- pop = instr_valid && instr_ready. can_push = (count < DEPTH) || pop.
- HSEL = (state==RUN) && can_push && !redirect.
- Fetch completes (push) when HSEL && HREADY: entry {fetch_pc, HRDATA} written at wr_ptr; fetch_pc += 4 (wraps modulo 2^32, 32'hFFFF_FFFC -> 0).
- HREADY low: no push, fetch_pc and HADDR held.
- Push and pop same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count distinguishes full (DEPTH) from empty (0).
- instr/instr_pc read combinationally from entry at rd_ptr; instr_valid = (count != 0).
- redirect (highest priority): count<=0, pointers<=0, fetch_pc<=redirect_pc & ~3; pop and push in that cycle are discarded (no push since HSEL=0; a handshake that cycle is not counted as consumed).
- Core must not rely on instr/instr_pc when instr_valid=0.

## Timing
- Reset: HSEL=0, HADDR=RESET_PC, instr_valid=0, count=0, instr=0, instr_pc=0 (storage cleared), state=IDLE.
- First fetch: 2nd cycle after HRESET deasserts (cycle 1 IDLE, cycle 2 HSEL=1 at RESET_PC); instr_valid=1 from cycle 3.
- Fetch-to-valid latency: 1 cycle (push at edge, valid next cycle).
- Redirect at cycle N: cycle N+1 HADDR=redirect_pc, HSEL=1; instr_valid=1 at N+2 with instr_pc=redirect_pc.
- Full and no pop: HSEL=0. Full with pop: HSEL=1, fetch continues without bubble.
- Steady state with instr_ready=1, HREADY=1: one instruction per cycle.
- Reset mid-operation overrides redirect and all handshakes; returns to reset values next edge.

## Configuration
- FETCH_BYPASS_EN defined: when count==0 and a fetch completes in RUN, instr_valid=1 same cycle with instr=HRDATA, instr_pc=fetch_pc; if instr_ready, word is not written (count stays 0); else written normally. Redirect-to-valid latency becomes 1 cycle (valid at N+1); first valid after reset at cycle 2.
- Undefined: no bypass; all words pass through the FIFO; latencies as in Timing.

## Test plan
- Reset release, HREADY=1, instr_ready=1, ROM word[k]=k -> HADDR 0,4,8,... from cycle 2; instr_pc/instr = 0/0, 4/1, 8/2 on consecutive cycles from cycle 3.
- instr_ready=0, DEPTH=4 -> exactly 4 pushes (PCs 0..C), count=4, HSEL=0 thereafter; raise instr_ready -> HSEL=1 same cycle, no bubble, PC 0x10 follows 0xC.
- HREADY low 3 cycles mid-stream at HADDR=0x8 -> HADDR held 0x8, count unchanged by push; word at 0x8 enqueued once after HREADY rises.
- redirect with redirect_pc=0x103 while count=3 -> next cycle count=0, HADDR=0x100; instr_valid at N+2 with instr_pc=0x100; no stale PC ever delivered.
- RESET_PC=32'hFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
- FETCH_BYPASS_EN defined, redirect to 0x40, instr_ready=1 -> instr_valid at N+1 with instr_pc=0x40, count stays 0.

Source files
------------

// File: rtl/ahb_fetch_queue.sv
// ahb_fetch_queue
//   Instruction prefetch queue between the core and a zero-wait-state AHB-Lite
//   instruction ROM. It issues sequential word fetches, buffers each returned
//   word with its PC in a DEPTH-entry FIFO, and hands entries to the core over
//   a valid/ready handshake. A redirect flushes the queue and restarts
//   fetching at the new PC.
//
//   Optional feature macro: FETCH_BYPASS_EN
//     When defined, a word fetched while the queue is empty is presented to
//     the core in the same cycle. If the core takes it, the word is never
//     written into the queue.
//
//   Parameters
//     DEPTH     FIFO entries (power of two, 2..16)
//     RESET_PC  first fetch address after reset (word aligned)
//
//   Ports
//     HCLK, HRESET          clock, synchronous active-high reset
//     HSEL, HADDR           fetch request and its word-aligned byte address
//     HREADY, HRDATA        bus ready and read data for the current HADDR
//     redirect, redirect_pc flush and restart fetching at redirect_pc
//     instr_valid, instr,   head-of-queue entry presented to the core
//     instr_pc, instr_ready
//     count                 occupied entries
//
//   States
//     IDLE | after reset, no fetch issued
//     RUN  | fetching; held until reset

module ahb_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    output logic                       HSEL,
    output logic [31:0]                HADDR,
    input  logic                       HREADY,
    input  logic [31:0]                HRDATA,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       instr_valid,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     mem_word_q [DEPTH];
    logic [31:0]     mem_word_d [DEPTH];
    logic [31:0]     mem_pc_q   [DEPTH];
    logic [31:0]     mem_pc_d   [DEPTH];

    logic fifo_empty;
    logic fifo_pop;
    logic can_push;
    logic hsel;
    logic fetch_ok;
    logic bypass;
    logic write_en;

    assign fifo_empty = (count_q == '0);
    // Pop from the stored entries only; using the raw valid here would close a
    // combinational loop through the bypass path. When full, the queue is
    // non-empty, so this gives the same can_push as checking the handshake.
    assign fifo_pop   = !fifo_empty && instr_ready;
    assign can_push   = (count_q != DEPTH_C) || fifo_pop;
    assign hsel       = (state_q == S_RUN) && can_push && !redirect;
    assign fetch_ok   = hsel && HREADY;

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty && fetch_ok;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that the core accepts right away never occupies a slot.
    assign write_en = fetch_ok && !(bypass && instr_ready);

    assign HSEL        = hsel;
    assign HADDR       = fetch_pc_q;
    assign count       = count_q;
    assign instr_valid = !fifo_empty || bypass;
    assign instr       = bypass ? HRDATA     : mem_word_q[rd_ptr_q];
    assign instr_pc    = bypass ? fetch_pc_q : mem_pc_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_word_d = mem_word_q;
        mem_pc_d   = mem_pc_q;

        case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            // Any handshake or fetch in this cycle is dropped with the flush.
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (fetch_ok) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (write_en) begin
                mem_word_d[wr_ptr_q] = HRDATA;
                mem_pc_d[wr_ptr_q]   = fetch_pc_q;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{(CW-1){1'b0}}, write_en}
                              - {{(CW-1){1'b0}}, fifo_pop};
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_word_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_word_q <= mem_word_d;
            mem_pc_q   <= mem_pc_d;
        end
    end

endmodule

// File: tb/tb_ahb_fetch_queue.sv
module tb_ahb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic          HREADY;
    logic [31:0]   HRDATA;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_ready;
    logic [CW-1:0] count;

    logic          hready_drv;
    logic [31:0]   junk;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    // ROM: word k lives at byte address 4*k. Garbage is driven while not ready.
    assign HREADY = hready_drv;
    assign HRDATA = hready_drv ? (HADDR >> 2) : junk;

    ahb_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .count       (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue is a list of {pc, word}; the fetcher is a PC
    // and a flag saying the first post-reset cycle has passed.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_run;

    initial begin : compare
        logic exp_hsel;
        @(posedge HCLK);
        mq.delete();
        m_pc  = RESET_PC;
        m_run = 1'b0;
        forever begin
            @(negedge HCLK);
            exp_hsel = m_run && !redirect &&
                       ((mq.size() < DEPTH) || (mq.size() > 0 && instr_ready));
            chk("hsel",  {31'b0, HSEL}, {31'b0, exp_hsel});
            chk("haddr", HADDR, m_pc);
            chk("count", 32'(count), 32'(mq.size()));
            chk("valid", {31'b0, instr_valid}, {31'b0, (mq.size() > 0)});
            if (mq.size() > 0) begin
                chk("instr_pc", instr_pc, mq[0].pc);
                chk("instr",    instr,    mq[0].w);
            end
            if (HRESET) begin
                mq.delete();
                m_pc  = RESET_PC;
                m_run = 1'b0;
            end else if (redirect) begin
                mq.delete();
                m_pc  = redirect_pc & 32'hFFFF_FFFC;
                m_run = 1'b1;
            end else begin
                if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
                if (exp_hsel && HREADY) begin
                    mq.push_back('{pc: m_pc, w: m_pc >> 2});
                    m_pc = m_pc + 32'd4;
                end
                m_run = 1'b1;
            end
        end
    end

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    initial begin : stim
        HRESET      = 1'b1;
        hready_drv  = 1'b1;
        junk        = 32'hDEAD_BEEF;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;
        repeat (3) next_cycle();
        @(negedge HCLK);
        chk("rst_hsel",  {31'b0, HSEL}, 32'd0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc",    instr_pc, 32'h0);

        // Reset release: cycle 1 idle, cycle 2 first fetch, cycle 3 first valid.
        next_cycle(); HRESET = 1'b0;
        @(negedge HCLK);
        chk("c1_hsel", {31'b0, HSEL}, 32'd0);
        next_cycle();
        @(negedge HCLK);
        chk("c2_hsel",  {31'b0, HSEL}, 32'd1);
        chk("c2_haddr", HADDR, 32'h0);
        chk("c2_valid", {31'b0, instr_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge HCLK);
            chk("seq_valid", {31'b0, instr_valid}, 32'd1);
            chk("seq_pc",    instr_pc, 32'(4 * k));
            chk("seq_instr", instr,    32'(k));
        end

        // Core stalls: queue fills with PCs C,10,14,18 and fetching stops.
        next_cycle(); instr_ready = 1'b0;
        repeat (7) next_cycle();
        @(negedge HCLK);
        chk("full_count", 32'(count), 32'd4);
        chk("full_hsel",  {31'b0, HSEL}, 32'd0);
        chk("full_pc",    instr_pc, 32'hC);
        chk("full_haddr", HADDR, 32'h1C);
        next_cycle(); instr_ready = 1'b1;
        @(negedge HCLK);
        chk("full_pop_hsel", {31'b0, HSEL}, 32'd1);

        // Bus wait states while HADDR=0x20.
        next_cycle(); hready_drv = 1'b0; junk = 32'h1234_5678;
        @(negedge HCLK);
        chk("nowait_pc",    instr_pc, 32'h10);
        chk("nowait_haddr", HADDR, 32'h20);
        chk("nowait_count", 32'(count), 32'd4);
        next_cycle(); junk = 32'h0BAD_F00D;
        next_cycle(); junk = 32'hCAFE_0000;
        @(negedge HCLK);
        chk("wait_haddr", HADDR, 32'h20);
        chk("wait_count", 32'(count), 32'd2);
        next_cycle(); hready_drv = 1'b1;

        // Build count=3 then redirect to an unaligned PC with a handshake.
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b0;
        next_cycle(); redirect = 1'b0;
        repeat (3) next_cycle();
        redirect = 1'b1; redirect_pc = 32'h103; instr_ready = 1'b1;
        @(negedge HCLK);
        chk("pre_redir_count", 32'(count), 32'd3);
        next_cycle(); redirect = 1'b0;
        @(negedge HCLK);
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_haddr", HADDR, 32'h100);
        chk("redir_hsel",  {31'b0, HSEL}, 32'd1);
        chk("redir_valid", {31'b0, instr_valid}, 32'd0);
        next_cycle();
        @(negedge HCLK);
        chk("redir2_valid", {31'b0, instr_valid}, 32'd1);
        chk("redir2_pc",    instr_pc, 32'h100);
        chk("redir2_instr", instr, 32'h40);

        // PC wraps modulo 2^32.
        next_cycle(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        next_cycle(); redirect = 1'b0;
        next_cycle();
        @(negedge HCLK);
        chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        next_cycle();
        @(negedge HCLK);
        chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        next_cycle();
        @(negedge HCLK);
        chk("wrap_pc2", instr_pc, 32'h0000_0000);
        chk("wrap_instr2", instr, 32'h0);

        // Random traffic, including occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            HRESET      = ($urandom_range(0, 199) == 0);
            hready_drv  = ($urandom_range(0, 3) != 0);
            junk        = $urandom;
            instr_ready = ($urandom_range(0, 4) < 3);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? ($urandom | 32'hFFFF_FF00) : $urandom;
        end
        next_cycle();
        HRESET = 1'b0; redirect = 1'b0;
        @(negedge HCLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
